// File: rtl/rv2a03_clk_pkg.sv
// ============================================================================
// Module : rv2a03_clk_pkg
// Brief  : Shared constants and types for the rv2a03 clock-enable generator.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package rv2a03_clk_pkg;

    localparam int ACC_W = 24;

    // Increments for a 64.125 MHz PLL clock: NTSC 21.4773 MHz, PAL 26.6017 MHz
    localparam logic [ACC_W-1:0] INC_NTSC = 24'h55BDD6;
    localparam logic [ACC_W-1:0] INC_PAL  = 24'h6A330E;

    localparam int CPU_DIV_NTSC = 12;
    localparam int CPU_DIV_PAL  = 16;

    typedef struct packed {
        logic mck;
        logic cpu;
        logic apu;
        logic m2;
    } ce_bus_t;

endpackage

`default_nettype wire

// File: rtl/rv2a03_nco.sv
// ============================================================================
// Module : rv2a03_nco
// Brief  : Phase accumulator with a glitch-free increment update handshake.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module rv2a03_nco #(
    parameter int               ACC_W    = 24,
    parameter logic [ACC_W-1:0] INC_INIT = 24'h55BDD6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_en,
    input  logic             i_clr,
    input  logic             i_inc_wr,
    input  logic [ACC_W-1:0] i_inc_data,
    output logic             o_carry,
    output logic             o_inc_busy
);

    logic [ACC_W-1:0] r_acc;
    logic [ACC_W-1:0] r_inc_q;
    logic [ACC_W-1:0] r_inc_pend;
    logic             r_busy;

    logic [ACC_W:0]   w_sum;
    logic             w_apply;

    assign w_sum = {1'b0, r_acc} + {1'b0, r_inc_q};

    // Swap the increment only at a phase-wrap boundary or while the phase is
    // not advancing, so the tick spacing never sees a partial step.
    assign w_apply = r_busy & (w_sum[ACC_W] | ~i_en | i_clr);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc      <= '0;
            r_inc_q    <= INC_INIT;
            r_inc_pend <= '0;
            r_busy     <= 1'b0;
        end else begin
            if (i_clr) begin
                r_acc <= '0;
            end else if (i_en) begin
                r_acc <= w_sum[ACC_W-1:0];
            end

            if (w_apply) begin
                r_inc_q <= r_inc_pend;
            end

            if (i_inc_wr) begin
                r_inc_pend <= i_inc_data;
                r_busy     <= 1'b1;
            end else if (w_apply) begin
                r_busy <= 1'b0;
            end
        end
    end

    assign o_carry    = w_sum[ACC_W] & i_en & ~i_clr;
    assign o_inc_busy = r_busy;

endmodule

`default_nettype wire

// File: rtl/rv2a03_ce_gen.sv
// ============================================================================
// Module : rv2a03_ce_gen
// Brief  : Master/CPU/APU clock enables and M2 phase derived from the PLL clock.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module rv2a03_ce_gen #(
    parameter int               ACC_W    = rv2a03_clk_pkg::ACC_W,
    parameter logic [ACC_W-1:0] INC_INIT = rv2a03_clk_pkg::INC_NTSC,
    parameter int               CPU_DIV  = rv2a03_clk_pkg::CPU_DIV_NTSC,
    parameter int               M2_LOW   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic             inc_wr,
    input  logic [ACC_W-1:0] inc_data,
    output logic             inc_busy,
    output logic             mck_ce,
    output logic             cpu_ce,
    output logic             apu_ce,
    output logic             m2,
    output logic [15:0]      cpu_cycles
);

    import rv2a03_clk_pkg::*;

    localparam int               DIV_W      = $clog2(CPU_DIV);
    localparam logic [DIV_W-1:0] c_DIV_LAST = DIV_W'(CPU_DIV - 1);
    localparam logic [DIV_W-1:0] c_M2_LOW   = DIV_W'(M2_LOW);

    logic             w_carry;
    logic             w_wrap;
    logic [DIV_W-1:0] w_div_next;

    logic [DIV_W-1:0] r_div;
    logic             r_apu_tgl;
    logic [15:0]      r_cycles;
    ce_bus_t          r_ce;

    rv2a03_nco #(
        .ACC_W    (ACC_W),
        .INC_INIT (INC_INIT)
    ) u_nco (
        .clk        (clk),
        .rst        (rst),
        .i_en       (en),
        .i_clr      (clr),
        .i_inc_wr   (inc_wr),
        .i_inc_data (inc_data),
        .o_carry    (w_carry),
        .o_inc_busy (inc_busy)
    );

    assign w_wrap     = (r_div == c_DIV_LAST);
    assign w_div_next = w_wrap ? '0 : r_div + 1'b1;

    // w_carry is already qualified by en and clr, so en=0 freezes everything here.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_div     <= '0;
            r_apu_tgl <= 1'b0;
            r_cycles  <= '0;
            r_ce      <= '0;
        end else if (clr) begin
            r_div     <= '0;
            r_apu_tgl <= 1'b0;
            r_ce      <= '0;
        end else begin
            r_ce.mck <= w_carry;
            r_ce.cpu <= w_carry & w_wrap;
            r_ce.apu <= w_carry & w_wrap & r_apu_tgl;
            if (w_carry) begin
                r_div   <= w_div_next;
                r_ce.m2 <= (w_div_next >= c_M2_LOW);
                if (w_wrap) begin
                    r_apu_tgl <= ~r_apu_tgl;
                    r_cycles  <= r_cycles + 16'd1;
                end
            end
        end
    end

    assign mck_ce     = r_ce.mck;
    assign cpu_ce     = r_ce.cpu;
    assign apu_ce     = r_ce.apu;
    assign m2         = r_ce.m2;
    assign cpu_cycles = r_cycles;

endmodule

`default_nettype wire

// File: tb/tb_rv2a03_ce_gen.sv
// ============================================================================
// Module : tb_rv2a03_ce_gen
// Brief  : Self-checking bench for rv2a03_ce_gen against a tick-counting model.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_rv2a03_ce_gen;

    localparam longint TWO24    = 64'd16777216;
    localparam longint INC_DEF  = 64'h55BDD6;
    localparam int     DIV      = 12;
    localparam int     M2L      = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b0;
    logic        clr = 1'b0;
    logic        inc_wr = 1'b0;
    logic [23:0] inc_data = '0;
    logic        inc_busy, mck_ce, cpu_ce, apu_ce, m2;
    logic [15:0] cpu_cycles;

    int checks = 0;
    int failures = 0;

    rv2a03_ce_gen dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .clr        (clr),
        .inc_wr     (inc_wr),
        .inc_data   (inc_data),
        .inc_busy   (inc_busy),
        .mck_ce     (mck_ce),
        .cpu_ce     (cpu_ce),
        .apu_ce     (apu_ce),
        .m2         (m2),
        .cpu_cycles (cpu_cycles)
    );

    always #5 clk = ~clk;

    // Reference: phase as an integer sum, divider as "master ticks since clear".
    longint m_acc, m_inc, m_pend, m_sum;
    bit     m_busy, m_carry, m_apply;
    int     m_ticks, m_pulses, m_cycles;
    bit     m_mck, m_cpu, m_apu, m_m2;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_acc = 0; m_inc = INC_DEF; m_pend = 0; m_busy = 0;
            m_ticks = 0; m_pulses = 0; m_cycles = 0;
            m_mck = 0; m_cpu = 0; m_apu = 0; m_m2 = 0;
        end else begin
            m_sum   = m_acc + m_inc;
            m_carry = (m_sum >= TWO24);
            m_apply = m_busy && (m_carry || !en || clr);
            if (clr) begin
                m_acc = 0; m_ticks = 0; m_pulses = 0;
                m_mck = 0; m_cpu = 0; m_apu = 0; m_m2 = 0;
            end else if (en) begin
                m_acc = m_sum % TWO24;
                m_mck = m_carry; m_cpu = 0; m_apu = 0;
                if (m_carry) begin
                    m_ticks++;
                    m_m2 = ((m_ticks % DIV) >= M2L);
                    if (m_ticks % DIV == 0) begin
                        m_cpu = 1;
                        m_pulses++;
                        m_apu = (m_pulses % 2 == 0);
                        m_cycles = (m_cycles + 1) % 65536;
                    end
                end
            end else begin
                m_mck = 0; m_cpu = 0; m_apu = 0;
            end
            if (m_apply) begin
                m_inc = m_pend; m_busy = 0;
            end
            if (inc_wr) begin
                m_pend = inc_data; m_busy = 1;
            end
        end
    end

    task automatic do_reset();
        rst = 1'b1; en = 1'b0; clr = 1'b0; inc_wr = 1'b0; inc_data = '0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Loads an increment while stopped so it is applied on the next edge.
    task automatic load_inc(input logic [23:0] v);
        en = 1'b0; inc_wr = 1'b1; inc_data = v;
        @(negedge clk);
        inc_wr = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({mck_ce, cpu_ce, apu_ce, m2, inc_busy, cpu_cycles} !== 21'd0) begin
            failures++;
            $display("FAIL reset_state: got %b/%h required all zero",
                     {mck_ce, cpu_ce, apu_ce, m2, inc_busy}, cpu_cycles);
        end
        rst = 1'b0;
    endtask

    task automatic test_ticks();
        int t = 0, last_mck = -1, last_cpu = -1, last_apu = -1;
        int first_cpu = -1, second_cpu = -1, first_apu = -1, ncpu = 0;
        do_reset();
        load_inc(24'h800000);
        en = 1'b1;
        repeat (150) begin
            @(negedge clk);
            t++;
            if (mck_ce) begin
                if (last_mck >= 0) begin
                    checks++;
                    if (t - last_mck != 2) begin
                        failures++;
                        $display("FAIL mck_spacing: got %0d required 2", t - last_mck);
                    end
                end
                last_mck = t;
            end
            if (cpu_ce) begin
                ncpu++;
                if (ncpu == 1) first_cpu = t;
                if (ncpu == 2) second_cpu = t;
                if (last_cpu >= 0) begin
                    checks++;
                    if (t - last_cpu != 24) begin
                        failures++;
                        $display("FAIL cpu_spacing: got %0d required 24", t - last_cpu);
                    end
                end
                last_cpu = t;
            end
            if (apu_ce) begin
                if (first_apu < 0) first_apu = t;
                if (last_apu >= 0) begin
                    checks++;
                    if (t - last_apu != 48) begin
                        failures++;
                        $display("FAIL apu_spacing: got %0d required 48", t - last_apu);
                    end
                end
                last_apu = t;
            end
        end
        checks++;
        if (first_cpu != 24) begin
            failures++;
            $display("FAIL first_cpu: got %0d required 24", first_cpu);
        end
        checks++;
        if (first_apu != second_cpu || first_apu != 48) begin
            failures++;
            $display("FAIL first_apu: got %0d required %0d (2nd cpu_ce, 48)", first_apu, second_cpu);
        end
    endtask

    task automatic test_m2();
        int t = 0, run = 0, since_cpu = 0, nrise = 0, nfall = 0;
        logic prev = 1'b0;
        do_reset();
        load_inc(24'h800000);
        en = 1'b1;
        repeat (130) begin
            @(negedge clk);
            t++;
            run++;
            if (mck_ce) since_cpu = cpu_ce ? 0 : since_cpu + 1;
            if (m2 && !prev) begin
                checks++;
                if (!mck_ce || since_cpu != M2L) begin
                    failures++;
                    $display("FAIL m2_rise_align: got mck=%b ticks=%0d required 1/%0d", mck_ce, since_cpu, M2L);
                end
                if (nrise > 0) begin
                    checks++;
                    if (run != 8) begin
                        failures++;
                        $display("FAIL m2_low_len: got %0d required 8", run);
                    end
                end
                nrise++;
                run = 0;
            end else if (!m2 && prev) begin
                checks++;
                if (!cpu_ce || run != 16) begin
                    failures++;
                    $display("FAIL m2_fall: got cpu_ce=%b high=%0d required 1/16", cpu_ce, run);
                end
                nfall++;
                run = 0;
            end
            prev = m2;
        end
        checks++;
        if (nfall < 4) begin
            failures++;
            $display("FAIL m2_activity: got %0d falls required >=4", nfall);
        end
    endtask

    task automatic test_inc_update();
        int t = 0, apply_t = -1, d, expd;
        int q[$];
        do_reset();
        load_inc(24'h800000);
        en = 1'b1;
        repeat (11) begin
            @(negedge clk); t++;
            if (mck_ce) q.push_back(t);
        end
        inc_wr = 1'b1; inc_data = 24'h400000;
        @(negedge clk); t++;
        inc_wr = 1'b0;
        if (mck_ce) q.push_back(t);
        checks++;
        if (inc_busy !== 1'b1) begin
            failures++;
            $display("FAIL busy_set: got %b required 1", inc_busy);
        end
        repeat (30) begin
            @(negedge clk); t++;
            if (apply_t < 0) begin
                checks++;
                if (inc_busy !== !mck_ce) begin
                    failures++;
                    $display("FAIL busy_until_carry: got %b required %b at t=%0d", inc_busy, !mck_ce, t);
                end
                if (mck_ce) apply_t = t;
            end
            if (mck_ce) q.push_back(t);
        end
        for (int i = 1; i < q.size(); i++) begin
            d = q[i] - q[i-1];
            expd = (apply_t >= 0 && q[i] > apply_t) ? 4 : 2;
            checks++;
            if (d != expd) begin
                failures++;
                $display("FAIL inc_switch_spacing: got %0d required %0d at t=%0d", d, expd, q[i]);
            end
        end
    endtask

    task automatic test_freeze_clr();
        int t = 0, resume_t = -1, tc, cpu_t = -1;
        logic [15:0] cyc;
        do_reset();
        load_inc(24'h800000);
        en = 1'b1;
        repeat (15) begin @(negedge clk); t++; end
        en = 1'b0;
        repeat (7) begin
            @(negedge clk); t++;
            checks++;
            if ({mck_ce, cpu_ce, apu_ce} !== 3'b000) begin
                failures++;
                $display("FAIL frozen_ce: got %b required 000", {mck_ce, cpu_ce, apu_ce});
            end
        end
        en = 1'b1;
        repeat (10) begin
            @(negedge clk); t++;
            if (mck_ce && resume_t < 0) resume_t = t;
        end
        checks++;
        if (resume_t != 23) begin
            failures++;
            $display("FAIL freeze_resume: got %0d required 23", resume_t);
        end
        cyc = cpu_cycles;
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        tc = 0;
        checks++;
        if ({mck_ce, cpu_ce, apu_ce, m2} !== 4'b0000 || cpu_cycles !== cyc) begin
            failures++;
            $display("FAIL clr_state: got %b cyc=%h required 0000 cyc=%h",
                     {mck_ce, cpu_ce, apu_ce, m2}, cpu_cycles, cyc);
        end
        repeat (30) begin
            @(negedge clk); tc++;
            if (cpu_ce && cpu_t < 0) cpu_t = tc;
        end
        checks++;
        if (cpu_t != 2 * DIV) begin
            failures++;
            $display("FAIL clr_cpu_delay: got %0d required %0d", cpu_t, 2 * DIV);
        end
    endtask

    task automatic test_count();
        localparam int N = 24000;
        int cnt = 0, consec = 0;
        logic prev = 1'b0;
        longint expc;
        do_reset();
        en = 1'b1;
        repeat (N) begin
            @(negedge clk);
            if (mck_ce) cnt++;
            if (mck_ce && prev) consec++;
            prev = mck_ce;
        end
        expc = (longint'(N) * INC_DEF) / TWO24;
        checks++;
        if (cnt != expc) begin
            failures++;
            $display("FAIL mck_count: got %0d required %0d", cnt, expc);
        end
        checks++;
        if (consec != 0) begin
            failures++;
            $display("FAIL mck_consecutive: got %0d required 0", consec);
        end
        checks++;
        if (cpu_cycles !== 16'((cnt / DIV) % 65536)) begin
            failures++;
            $display("FAIL cpu_cycles_count: got %0d required %0d", cpu_cycles, (cnt / DIV) % 65536);
        end
    endtask

    task automatic test_random();
        do_reset();
        repeat (3000) begin
            @(negedge clk);
            checks++;
            if ({mck_ce, cpu_ce, apu_ce, m2, inc_busy, cpu_cycles} !==
                {m_mck, m_cpu, m_apu, m_m2, m_busy, 16'(m_cycles)}) begin
                failures++;
                $display("FAIL random_vs_model: got %b/%h required %b/%h",
                         {mck_ce, cpu_ce, apu_ce, m2, inc_busy}, cpu_cycles,
                         {m_mck, m_cpu, m_apu, m_m2, m_busy}, 16'(m_cycles));
            end
            en     = ($urandom_range(0, 9) != 0);
            clr    = ($urandom_range(0, 59) == 0);
            inc_wr = ($urandom_range(0, 24) == 0);
            case ($urandom_range(0, 7))
                0:       inc_data = 24'h000000;
                1:       inc_data = 24'hFFFFFF;
                2:       inc_data = 24'h800000;
                default: inc_data = 24'($urandom_range(32'h080000, 32'hFFFFFF));
            endcase
        end
        en = 1'b0; clr = 1'b0; inc_wr = 1'b0;
    endtask

    task automatic test_rst_midrun();
        int k = 0;
        do_reset();
        load_inc(24'h800000);
        en = 1'b1;
        while (!cpu_ce && k < 100) begin
            @(negedge clk); k++;
        end
        checks++;
        if (!cpu_ce) begin
            failures++;
            $display("FAIL wait_cpu_ce: got timeout after %0d clk required a cpu_ce", k);
        end
        #1 rst = 1'b1;
        #1;
        checks++;
        if ({mck_ce, cpu_ce, apu_ce, m2, inc_busy, cpu_cycles} !== 21'd0) begin
            failures++;
            $display("FAIL async_rst: got %b/%h required all zero",
                     {mck_ce, cpu_ce, apu_ce, m2, inc_busy}, cpu_cycles);
        end
        @(negedge clk);
        rst = 1'b0;
        load_inc(24'h800000);
        en = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            checks++;
            if (mck_ce !== ((i % 2) == 0) || mck_ce !== m_mck) begin
                failures++;
                $display("FAIL post_rst_mck: got %b required %b at clk %0d", mck_ce, (i % 2) == 0, i);
            end
        end
    endtask

    initial begin
        test_reset();
        test_ticks();
        test_m2();
        test_inc_update();
        test_freeze_clr();
        test_count();
        test_random();
        test_rst_midrun();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
